// File: rtl/seq_comparator.sv
// seq_comparator
//   Chunk-serial magnitude/equality comparator. Operands are compared CHUNK
//   bits per cycle, MSB chunk first, and the comparison stops at the first
//   chunk that differs. Six relational modes, signed or unsigned operands,
//   valid/ready handshakes on request and result sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (high whenever idle, also in reset)
//   a, b       operands, WIDTH bits
//   mode       0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6-7 reserved (result = 0)
//   is_signed  1 = two's-complement compare
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     A <mode> B
//   a_eq_b     A == B
//   a_lt_b     A < B with the signedness of the request
//
// States
//   state  | meaning
//   S_IDLE | waiting for a request, in_ready = 1
//   S_RUN  | comparing chunk k of the latched operands
//   S_DONE | result and flags held, out_valid = 1 until handshake
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("seq_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        mode_q;
  logic              signed_q;
  logic [KW-1:0]     k_q, k_d;
  logic              result_q, eq_q, lt_q;

  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              chunk_ne, chunk_lt;
  logic              load, finish;
  logic              eq_d, lt_d;

  function automatic logic relation(input logic [2:0] m, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (m)
      3'd0:    r = eq;
      3'd1:    r = ~eq;
      3'd2:    r = lt;
      3'd3:    r = lt | eq;
      3'd4:    r = ~lt & ~eq;
      3'd5:    r = ~lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Chunk k = 0 is the most significant chunk.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        chunk_a = a_q[(NCHUNK-1-i)*CHUNK +: CHUNK];
        chunk_b = b_q[(NCHUNK-1-i)*CHUNK +: CHUNK];
      end
    end
    // Flipping the sign bit maps two's complement onto offset binary, so an
    // unsigned compare of the top chunk orders signed values correctly.
    if (signed_q && k_q == '0) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  assign chunk_ne = (chunk_a != chunk_b);
  assign chunk_lt = (chunk_a < chunk_b);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load    = 1'b0;
    finish  = 1'b0;
    eq_d    = 1'b0;
    lt_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (chunk_ne) begin
          finish  = 1'b1;
          lt_d    = chunk_lt;
          state_d = S_DONE;
        end else if (k_q == K_LAST) begin
          finish  = 1'b1;
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      signed_q <= 1'b0;
      k_q      <= '0;
      result_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (load) begin
        a_q      <= a;
        b_q      <= b;
        mode_q   <= mode;
        signed_q <= is_signed;
      end
      if (finish) begin
        eq_q     <= eq_d;
        lt_q     <= lt_d;
        result_q <= relation(mode_q, eq_d, lt_d);
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign a_eq_b    = eq_q;
  assign a_lt_b    = lt_q;

endmodule

// File: tb/tb_seq_comparator.sv
module tb_seq_comparator;
  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, is_signed, out_valid, out_ready;
  logic          result, a_eq_b, a_lt_b;
  logic [W-1:0]  a, b;
  logic [2:0]    mode;

  logic          iv16, ir16, s16, ov16, or16, r16, eq16, lt16;
  logic [15:0]   a16, b16;
  logic [2:0]    m16;

  seq_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b)
  );

  seq_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .mode(m16), .is_signed(s16),
    .out_valid(ov16), .out_ready(or16),
    .result(r16), .a_eq_b(eq16), .a_lt_b(lt16)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: full-width arithmetic compare; latency from the position of
  // the most significant differing bit.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mm,
                       input logic ms, output logic r, output logic e, output logic l,
                       output int lat);
    logic [31:0] x;
    int p;
    e = (ma == mb);
    l = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
    case (mm)
      3'd0: r = e;
      3'd1: r = !e;
      3'd2: r = l;
      3'd3: r = l || e;
      3'd4: r = !l && !e;
      3'd5: r = !l;
      default: r = 1'b0;
    endcase
    x = ma ^ mb;
    p = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    lat = (p < 0) ? N + 1 : (31 - p) / C + 2;
  endtask

  // Compare process for the 32-bit instance, sampled on the falling edge.
  bit          busy = 0;
  int          edges = 0;
  logic        m_res, m_eq, m_lt;
  int          m_lat = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_a_eq_b", a_eq_b, 0);
      check("rst_a_lt_b", a_lt_b, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("in_ready", in_ready, !busy);
      if (busy) begin
        edges++;
        check("out_valid", out_valid, edges >= m_lat);
        if (out_valid === 1'b1) begin
          check("result", result, m_res);
          check("a_eq_b", a_eq_b, m_eq);
          check("a_lt_b", a_lt_b, m_lt);
          if (out_ready) busy = 0;
        end
      end else begin
        check("idle_out_valid", out_valid, 0);
        if (in_valid) begin
          model(a, b, mode, is_signed, m_res, m_eq, m_lt, m_lat);
          busy  = 1;
          edges = 0;
        end
      end
    end
  end

  task automatic req(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tm,
                     input logic ts, input int hold, input bit lit, input logic lr,
                     input logic le, input logic ll, input int llat, input string nm);
    int n;
    bit got;
    @(posedge clk); #1;
    in_valid = 1; a = ta; b = tb_; mode = tm; is_signed = ts;
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; mode = 3'($urandom); is_signed = 1'($urandom);
    n = 1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    if (!got) check({nm, "_timeout"}, 0, 1);
    else if (lit) begin
      check({nm, "_result"}, result, lr);
      check({nm, "_a_eq_b"}, a_eq_b, le);
      check({nm, "_a_lt_b"}, a_lt_b, ll);
      check({nm, "_latency"}, n, llat);
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int sel, nb;
    bit got16;
    rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; mode = 0; is_signed = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; m16 = 0; s16 = 0;
    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    req(32'h12345678, 32'h12345678, 3'd1, 0, 0, 1, 0, 1, 0, 5, "t1_ne_equal");
    req(32'h80000000, 32'h00000001, 3'd4, 0, 0, 1, 1, 0, 0, 2, "t2_gt_unsigned");
    req(32'h80000000, 32'h00000001, 3'd4, 1, 0, 1, 0, 0, 1, 2, "t2_gt_signed");
    req(32'h000000FF, 32'h000000FE, 3'd2, 0, 0, 1, 0, 0, 0, 5, "t3_lt");

    // GE with three cycles of back-pressure
    fork
      req(32'h000000FF, 32'h000000FE, 3'd5, 0, 3, 1, 1, 0, 0, 5, "t3_ge");
      begin
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t3_hold_out_valid", out_valid, 1);
        check("t3_hold_in_ready", in_ready, 0);
        check("t3_hold_result", result, 1);
      end
    join
    @(negedge clk);
    check("t3_after_hs_in_ready", in_ready, 1);

    // Reset during the chunk-2 RUN cycle
    @(posedge clk); #1;
    in_valid = 1; a = 32'hFF; b = 32'hFE; mode = 3'd2; is_signed = 0;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("t4_async_out_valid", out_valid, 0);
    check("t4_async_result", result, 0);
    check("t4_async_a_eq_b", a_eq_b, 0);
    check("t4_async_a_lt_b", a_lt_b, 0);
    check("t4_async_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      check("t4_no_stale_out_valid", out_valid, 0);
      check("t4_post_in_ready", in_ready, 1);
    end
    req(32'd5, 32'd5, 3'd0, 0, 0, 1, 1, 1, 0, 5, "t4_eq_after_reset");
    req(32'd1, 32'd2, 3'd6, 0, 0, 1, 0, 0, 1, 5, "t5_reserved");

    // Randomized requests against the model
    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
      endcase
      req(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3),
          0, 0, 0, 0, 0, "rand");
    end

    // Single-chunk instance: signed LE
    @(posedge clk); #1;
    iv16 = 1; a16 = 16'hFFFF; b16 = 16'h0001; m16 = 3'd3; s16 = 1;
    @(posedge clk); #1 iv16 = 0;
    nb = 1;
    got16 = 0;
    for (int i = 0; i < 20 && !got16; i++) begin
      @(negedge clk);
      if (ov16 === 1'b1) got16 = 1;
      else begin
        @(posedge clk);
        nb++;
      end
    end
    check("t6_got", got16, 1);
    check("t6_latency", nb, 2);
    check("t6_result", r16, 1);
    check("t6_a_lt_b", lt16, 1);
    check("t6_a_eq_b", eq16, 0);
    @(posedge clk); #1 or16 = 1;
    @(posedge clk); #1 or16 = 0;

    // Back-to-back with in_valid held: accepts only from IDLE, period 3
    @(posedge clk); #1;
    iv16 = 1; or16 = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t6_b2b_in_ready", ir16, (i % 3) == 0);
      check("t6_b2b_out_valid", ov16, (i % 3) == 2);
      if ((i % 3) == 2) check("t6_b2b_result", r16, 1);
    end
    @(posedge clk); #1;
    iv16 = 0; or16 = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Parametrised, multi-mode magnitude/equality comparator; successor to the fixed 32-bit inequality comparator in the factorial datapath.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and terminates early on the first differing chunk.
- Supports six relational modes and signed or unsigned operands, with valid/ready handshakes on both sides.
- Sits between the factorial controller and any loop-bound or overflow check that needs more than a != b.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2.
CHUNK, 8, bits compared per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails via $error.
NCHUNK (localparam), WIDTH/CHUNK, number of chunks.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
a  in  WIDTH  operand A
b  in  WIDTH  operand B
mode  in  3  0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6-7 reserved
is_signed  in  1  1 = two's-complement compare
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  1  selected relation: A op B
a_eq_b  out  1  flag, A == B
a_lt_b  out  1  flag, A < B (uses signedness of the request)

Behaviour:
- Reset: async on rst_n low; state IDLE; out_valid, result, a_eq_b and a_lt_b = 0; internal operand, mode and index registers = 0.
- in_ready is decoded combinationally as (state == IDLE), so it reads 1 while in reset.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: on in_valid & in_ready at an edge, latch a, b, mode and is_signed; set chunk index k = 0 (MSB chunk); go to RUN. Inputs are ignored at all other times.
- RUN: each cycle, compare chunk k of the latched A and B.
  - For the top chunk (k = 0) with is_signed = 1, invert bit CHUNK-1 of both chunks before the magnitude compare (offset-binary trick); no other chunk is adjusted.
  - Chunks differ: set a_lt_b = (A_chunk < B_chunk); set a_eq_b = 0; go to DONE.
  - Chunks equal and k == NCHUNK-1: set a_eq_b = 1, a_lt_b = 0; go to DONE.
  - Otherwise: k <= k + 1; stay in RUN.
- result is registered together with the flags on the RUN -> DONE edge:
  - EQ = eq; NE = !eq; LT = lt; LE = lt | eq; GT = !lt & !eq; GE = !lt.
  - Reserved modes give result = 0; flags remain valid.
- DONE: out_valid = 1. result and flags are held stable until out_valid & out_ready at an edge, then go to IDLE and clear out_valid.
- Latency is counted in edges from the accept edge to the first cycle with out_valid high:
  - k+2 when the first difference is in chunk k;
  - NCHUNK+1 when the operands are equal.
- No overlap between requests: the earliest next accept is the edge after the result handshake.
- Back-pressure: out_ready held low keeps the block in DONE indefinitely, with in_ready = 0.
- Reset mid-operation (RUN or DONE) discards the request; no out_valid pulse is produced.
- No arithmetic wrap: k never exceeds NCHUNK-1. The width of k is $clog2(NCHUNK), minimum 1.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
1. a=0x12345678, b=0x12345678, mode=NE -> result=0, a_eq_b=1, a_lt_b=0; out_valid first high 5 edges after accept.
2. a=0x80000000, b=0x00000001, is_signed=0, mode=GT -> result=1, a_lt_b=0; latency 2.
   Same operands with is_signed=1 -> result=0, a_lt_b=1; latency 2.
3. a=0x000000FF, b=0x000000FE, unsigned, mode=LT -> result=0. Repeat with mode=GE -> result=1. Both have latency 5.
   Hold out_ready=0 for 3 cycles: result, flags and out_valid stay stable, in_ready=0. Release: handshake, then in_ready=1 the next cycle.
4. Assert rst_n low during the RUN cycle for chunk 2 of a 0x000000FF vs 0x000000FE request -> out_valid, result and flags go to 0 immediately, asynchronously. After release, in_ready=1 and no stale result appears.
   A new request a=5, b=5, mode=EQ returns result=1.
5. mode=6 with a=1, b=2, unsigned -> result=0, a_lt_b=1, a_eq_b=0.
6. WIDTH=16, CHUNK=16 (single chunk): a=0xFFFF, b=0x0001, signed LE -> result=1, latency 2.
   Back-to-back requests with in_valid held high are accepted only while in IDLE.
